// File: rtl/truth_table_sweeper_if.sv
// rtl/truth_table_sweeper_if.sv - control, status and probe bundle for the truth-table sweeper
interface truth_table_sweeper_if;
  logic       start;
  logic       abort;
  logic [7:0] expected;
  logic       dut_out;
  logic [2:0] dut_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] captured;
  logic [7:0] mismatch;

  modport master (
    output start, abort, expected, dut_out,
    input  dut_in, busy, done, pass, captured, mismatch
  );

  modport slave (
    input  start, abort, expected, dut_out,
    output dut_in, busy, done, pass, captured, mismatch
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - steps a 3-input function through all 8 rows and compares the
// measured truth table against a latched expected table
module truth_table_sweeper #(
  parameter int SETTLE = 4
) (
  input logic                  clk,
  input logic                  rst,
  truth_table_sweeper_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_REPORT} state_t;

  localparam logic [7:0] LAST_CNT = 8'(SETTLE - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt;
  logic [2:0] r_row, w_row;
  logic [7:0] r_exp, w_exp;
  logic [2:0] r_dut_in, w_dut_in;
  logic       r_busy, w_busy;
  logic       r_done, w_done;
  logic       r_pass, w_pass;
  logic [7:0] r_captured, w_captured;
  logic [7:0] r_mismatch, w_mismatch;
  logic       w_accept;
  logic       w_sample;

  // abort has priority over both a new start and a pending row sample
  assign w_accept = (r_state == S_IDLE) && bus.start && !bus.abort;
  assign w_sample = (r_state == S_SETTLE) && !bus.abort && (r_cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_row      <= '0;
      r_exp      <= '0;
      r_dut_in   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_captured <= '0;
      r_mismatch <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt;
      r_row      <= w_row;
      r_exp      <= w_exp;
      r_dut_in   <= w_dut_in;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_pass     <= w_pass;
      r_captured <= w_captured;
      r_mismatch <= w_mismatch;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_SETTLE;
      S_SETTLE: begin
        if (bus.abort)                          w_state_nxt = S_IDLE;
        else if (w_sample && (r_row == 3'd7))   w_state_nxt = S_REPORT;
      end
      S_REPORT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // next values of every registered output, so each output changes together with the state
  always_comb begin
    w_cnt      = r_cnt;
    w_row      = r_row;
    w_exp      = r_exp;
    w_dut_in   = r_dut_in;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_pass     = r_pass;
    w_captured = r_captured;
    w_mismatch = r_mismatch;
    case (r_state)
      S_IDLE: begin
        w_busy   = 1'b0;
        w_dut_in = '0;
        if (w_accept) begin
          w_exp      = bus.expected;
          w_captured = '0;
          w_pass     = 1'b0;
          w_mismatch = '0;
          w_row      = '0;
          w_cnt      = '0;
          w_busy     = 1'b1;
        end
      end
      S_SETTLE: begin
        if (bus.abort) begin
          w_busy     = 1'b0;
          w_dut_in   = '0;
          w_pass     = 1'b0;
          w_mismatch = '0;
          w_cnt      = '0;
        end else if (w_sample) begin
          w_captured[r_row] = bus.dut_out;
          w_cnt             = '0;
          if (r_row != 3'd7) begin
            w_row    = r_row + 3'd1;
            w_dut_in = r_row + 3'd1;
          end else begin
            w_done     = 1'b1;
            w_pass     = (w_captured == r_exp);
            w_mismatch = w_captured ^ r_exp;
          end
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      S_REPORT: begin
        w_busy   = 1'b0;
        w_dut_in = '0;
      end
      default: begin
        w_busy   = 1'b0;
        w_dut_in = '0;
      end
    endcase
  end

  assign bus.dut_in   = r_dut_in;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.pass     = r_pass;
  assign bus.captured = r_captured;
  assign bus.mismatch = r_mismatch;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - scoreboard bench for truth_table_sweeper at SETTLE=4 and SETTLE=1
module tb_truth_table_sweeper;

  typedef struct {
    logic [7:0] cap;
    logic       pass;
    logic [7:0] mm;
    int         cyc;
  } exp_t;

  logic clk;
  logic rst;
  logic [7:0] model = 8'hD6;

  truth_table_sweeper_if if4();
  truth_table_sweeper_if if1();

  truth_table_sweeper #(.SETTLE(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));
  truth_table_sweeper #(.SETTLE(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));

  assign if4.dut_out = model[if4.dut_in];
  assign if1.dut_out = model[if1.dut_in];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t       sb[$];
  exp_t       e;
  int         n_vec = 0;
  int         n_mis = 0;
  int         done_cnt;
  int         done_cycle;
  logic       obs_busy_start;
  logic [2:0] obs_dut_in [0:63];
  logic       obs_busy   [0:63];

  // cycle 0 carries start; observation after edge k belongs to cycle k+1
  task automatic drive_sweep4(input logic [7:0] ex, input bit extra_starts, input bit chg_exp,
                              input int abort_at, input int n_edges);
    @(negedge clk);
    if4.expected = ex;
    if4.start    = 1'b1;
    @(posedge clk); #1;
    obs_busy_start = if4.busy;
    done_cnt   = 0;
    done_cycle = -1;
    for (int k = 1; k <= n_edges; k++) begin
      @(negedge clk);
      if4.start = extra_starts && (k == 5 || k == 33);
      if4.abort = (k == abort_at);
      if (chg_exp && k == 10) if4.expected = ~ex;
      @(posedge clk); #1;
      obs_dut_in[k] = if4.dut_in;
      obs_busy[k]   = if4.busy;
      if (if4.done) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = k + 1;
      end
    end
    if4.start = 1'b0;
    if4.abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({if4.busy, if4.done, if4.pass, if4.captured, if4.mismatch, if4.dut_in} !== 22'd0) begin
      n_mis++;
      $display("FAIL reset_s4 got busy=%b done=%b pass=%b cap=%h mm=%h in=%0d want all 0",
               if4.busy, if4.done, if4.pass, if4.captured, if4.mismatch, if4.dut_in);
    end
    n_vec++;
    if ({if1.busy, if1.done, if1.pass, if1.captured, if1.mismatch, if1.dut_in} !== 22'd0) begin
      n_mis++;
      $display("FAIL reset_s1 got busy=%b done=%b pass=%b cap=%h mm=%h in=%0d want all 0",
               if1.busy, if1.done, if1.pass, if1.captured, if1.mismatch, if1.dut_in);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_result(input string name);
    e = sb.pop_front();
    n_vec++;
    if (if4.captured !== e.cap) begin
      n_mis++; $display("FAIL %s captured got %h want %h", name, if4.captured, e.cap);
    end
    n_vec++;
    if (if4.pass !== e.pass) begin
      n_mis++; $display("FAIL %s pass got %b want %b", name, if4.pass, e.pass);
    end
    n_vec++;
    if (if4.mismatch !== e.mm) begin
      n_mis++; $display("FAIL %s mismatch got %h want %h", name, if4.mismatch, e.mm);
    end
    n_vec++;
    if (done_cycle !== e.cyc) begin
      n_mis++; $display("FAIL %s done_cycle got %0d want %0d", name, done_cycle, e.cyc);
    end
  endtask

  task automatic test_sweep_pass();
    sb.push_back('{cap: 8'hD6, pass: 1'b1, mm: 8'h00, cyc: 33});
    drive_sweep4(8'hD6, 1'b0, 1'b0, 0, 40);
    n_vec++;
    if (obs_busy_start !== 1'b1) begin
      n_mis++; $display("FAIL pass_busy_after_start got %b want 1", obs_busy_start);
    end
    for (int r = 0; r < 8; r++) begin
      n_vec++;
      if (obs_dut_in[4 * r + 2] !== 3'(r)) begin
        n_mis++; $display("FAIL pass_dut_in_row%0d got %0d want %0d", r, obs_dut_in[4 * r + 2], r);
      end
    end
    n_vec++;
    if (done_cnt !== 1) begin
      n_mis++; $display("FAIL pass_done_count got %0d want 1", done_cnt);
    end
    n_vec++;
    if (obs_busy[40] !== 1'b0) begin
      n_mis++; $display("FAIL pass_busy_idle got %b want 0", obs_busy[40]);
    end
    check_result("sweep_pass");
  endtask

  task automatic test_abort();
    @(negedge clk);
    if4.start = 1'b1;
    if4.abort = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    if4.abort = 1'b0;
    n_vec++;
    if (if4.busy !== 1'b0 || if4.captured !== 8'hD6) begin
      n_mis++; $display("FAIL abort_wins_idle got busy=%b cap=%h want busy=0 cap=d6", if4.busy, if4.captured);
    end
    sb.push_back('{cap: 8'b0000_0110, pass: 1'b0, mm: 8'h00, cyc: -1});
    drive_sweep4(8'hD6, 1'b0, 1'b0, 14, 40);
    n_vec++;
    if (obs_busy[13] !== 1'b1 || obs_busy[14] !== 1'b0) begin
      n_mis++; $display("FAIL abort_idle_timing got busy13=%b busy14=%b want 1,0", obs_busy[13], obs_busy[14]);
    end
    n_vec++;
    if (obs_dut_in[14] !== 3'd0) begin
      n_mis++; $display("FAIL abort_dut_in got %0d want 0", obs_dut_in[14]);
    end
    n_vec++;
    if (done_cnt !== 0) begin
      n_mis++; $display("FAIL abort_done_count got %0d want 0", done_cnt);
    end
    check_result("abort");
  endtask

  task automatic test_sweep_fail();
    sb.push_back('{cap: 8'hD6, pass: 1'b0, mm: 8'hBD, cyc: 33});
    drive_sweep4(8'h6B, 1'b0, 1'b0, 0, 40);
    check_result("sweep_fail");
  endtask

  task automatic test_back_to_back();
    sb.push_back('{cap: 8'hD6, pass: 1'b1, mm: 8'h00, cyc: 33});
    drive_sweep4(8'hD6, 1'b1, 1'b1, 0, 45);
    n_vec++;
    if (done_cnt !== 1) begin
      n_mis++; $display("FAIL busy_start_done_count got %0d want 1", done_cnt);
    end
    n_vec++;
    if (obs_busy[45] !== 1'b0) begin
      n_mis++; $display("FAIL busy_start_restarted got busy=%b want 0", obs_busy[45]);
    end
    check_result("busy_start");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    if4.expected = 8'hD6;
    if4.start    = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if4.start = 1'b0;
      @(posedge clk);
    end
    #1;
    n_vec++;
    if (if4.busy !== 1'b1) begin
      n_mis++; $display("FAIL areset_pre_busy got %b want 1", if4.busy);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if ({if4.busy, if4.done, if4.pass, if4.captured, if4.mismatch, if4.dut_in} !== 22'd0) begin
      n_mis++;
      $display("FAIL areset_immediate got busy=%b done=%b pass=%b cap=%h mm=%h in=%0d want all 0",
               if4.busy, if4.done, if4.pass, if4.captured, if4.mismatch, if4.dut_in);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (if4.done) done_cnt++;
    end
    n_vec++;
    if (done_cnt !== 0 || if4.busy !== 1'b0) begin
      n_mis++; $display("FAIL areset_discard got done_count=%0d busy=%b want 0,0", done_cnt, if4.busy);
    end
  endtask

  task automatic test_settle1();
    @(negedge clk);
    if1.expected = 8'hD6;
    if1.start    = 1'b1;
    @(posedge clk); #1;
    done_cnt   = 0;
    done_cycle = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if1.start = 1'b0;
      @(posedge clk); #1;
      obs_dut_in[k] = if1.dut_in;
      if (if1.done) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = k + 1;
      end
    end
    n_vec++;
    if (obs_dut_in[3] !== 3'd3) begin
      n_mis++; $display("FAIL s1_dut_in got %0d want 3", obs_dut_in[3]);
    end
    n_vec++;
    if (done_cycle !== 9 || done_cnt !== 1) begin
      n_mis++; $display("FAIL s1_done got cycle=%0d count=%0d want 9,1", done_cycle, done_cnt);
    end
    n_vec++;
    if (if1.captured !== 8'hD6 || if1.pass !== 1'b1 || if1.mismatch !== 8'h00) begin
      n_mis++; $display("FAIL s1_result got cap=%h pass=%b mm=%h want d6,1,00", if1.captured, if1.pass, if1.mismatch);
    end
  endtask

  initial begin
    if4.start = 1'b0; if4.abort = 1'b0; if4.expected = 8'h00;
    if1.start = 1'b0; if1.abort = 1'b0; if1.expected = 8'h00;
    test_reset();
    test_sweep_pass();
    test_abort();
    test_sweep_fail();
    test_back_to_back();
    test_async_reset();
    test_settle1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter SETTLE, default 4, meaning cycles each input combination is held before sampling; legal range 1..255.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request a full 8-row sweep; sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  terminate a sweep in progress.
REQ-006 SHALL have port expected  input  8  expected truth table, bit k = expected output for input row k.
REQ-007 SHALL have port dut_out  input  1  output of the 3-input logic function under test.
REQ-008 SHALL have port dut_in  output  3  drives {in1,in2,in3} of the function; bit 2 = in1.
REQ-009 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse on sweep completion.
REQ-011 SHALL have port pass  output  1  captured table equals latched expected table.
REQ-012 SHALL have port captured  output  8  measured truth table, bit k = dut_out sampled for row k.
REQ-013 SHALL have port mismatch  output  8  captured XOR latched expected.

Function
REQ-014 SHALL implement FSM states IDLE, SETTLE, REPORT; all outputs registered.
REQ-015 IDLE: dut_in = 0, busy = 0; on start = 1 SHALL latch expected, clear captured, set row index 0, settle counter 0, and go to SETTLE.
REQ-016 SETTLE: busy = 1, dut_in = row index; counter increments each cycle.
REQ-017 SETTLE, counter = SETTLE-1: SHALL write dut_out into captured[row]; if row < 7, row and dut_in increment and counter clears, staying in SETTLE; if row = 7, go to REPORT.
REQ-018 REPORT lasts exactly one cycle: done = 1, busy = 1, pass and mismatch updated from final captured and latched expected; next state IDLE.
REQ-019 Latency: start sampled in cycle 0 -> rows sampled in cycles SETTLE, 2*SETTLE, ..., 8*SETTLE -> done high in cycle 8*SETTLE+1.
REQ-020 pass, mismatch, captured SHALL hold their values from REPORT until the next accepted start.
REQ-021 start while busy (SETTLE or REPORT) SHALL be ignored and has no effect on the sweep in progress.
REQ-022 abort = 1 in SETTLE SHALL return to IDLE next cycle: no done pulse, pass = 0, mismatch = 0, captured holds rows sampled so far (unsampled bits 0), dut_in = 0.
REQ-023 abort in REPORT or IDLE SHALL be ignored; abort and start together in IDLE: abort wins, no sweep starts.
REQ-024 Changes to expected during a sweep SHALL NOT affect the result (latched copy used).
REQ-025 SETTLE = 1 SHALL sample every cycle, giving done in cycle 9.

Reset
REQ-026 rst = 1 SHALL immediately force IDLE, dut_in = 0, busy = 0, done = 0, pass = 0, captured = 0, mismatch = 0, counters = 0, latched expected = 0.
REQ-027 Reset asserted mid-sweep SHALL discard the sweep; no done pulse after release; first start after release begins a fresh sweep.

Verification
REQ-028 Bench models dut_out with rows 0..7 = 0,1,1,0,1,0,1,1; SETTLE = 4; expected = 8'hD6; start pulse in cycle 0 -> dut_in steps 0..7 every 4 cycles, done in cycle 33, captured = 8'hD6, pass = 1, mismatch = 8'h00.
REQ-029 Same model, expected = 8'h6B -> captured = 8'hD6, pass = 0, mismatch = 8'hBD, done in cycle 33.
REQ-030 Start pulses in cycles 5 and 33 during a sweep -> ignored, exactly one done pulse in cycle 33; expected changed in cycle 10 -> result unchanged.
REQ-031 Abort in cycle 14 (row 3 not yet sampled) -> IDLE in cycle 15, no done, captured = 8'b0000_0110, pass = 0, dut_in = 0.
REQ-032 rst asserted asynchronously in cycle 20 mid-sweep -> all outputs 0 before next edge; after release, new start with SETTLE = 1 gives done in cycle 9 with correct captured.
